// File: rtl/alu_exec_unit.sv
// Single-outstanding ALU execution unit behind valid/ready request/response channels.
// One-cycle ops finish on the accept edge; MUL runs a DATA_W-step shift-add before responding.
module alu_exec_unit #(
  parameter int DATA_W  = 8,
  parameter int MUL_CYC = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [3:0]        req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_e,
  output logic [1:0]        rsp_cc,
  output logic              busy
);

  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] e;
    logic [1:0]        cc;
  } rsp_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [CW-1:0]       cnt;
  logic [2*DATA_W-1:0] acc, acc_nxt;
  logic [DATA_W:0]     sum_w, dif_w;
  rsp_t                alu_res, mul_res;
  logic                accept, mul_last;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = req_valid & req_ready;
  assign mul_last  = (cnt == CW'(MUL_CYC - 1));

  // Extra top bit of the widened add/sub is carry out / borrow.
  assign sum_w = {1'b0, req_a} + {1'b0, req_b};
  assign dif_w = {1'b0, req_a} - {1'b0, req_b};

  always_comb begin
    alu_res = '0;
    case (req_op)
      4'd0: begin alu_res.e = sum_w[DATA_W-1:0]; alu_res.cc[1] = sum_w[DATA_W]; end
      4'd1: begin alu_res.e = dif_w[DATA_W-1:0]; alu_res.cc[1] = dif_w[DATA_W]; end
      4'd2: alu_res.e = req_a & req_b;
      4'd3: alu_res.e = req_a | req_b;
      4'd4: alu_res.e = req_a ^ req_b;
      4'd5: alu_res.e = ~req_a;
      4'd6: begin alu_res.e = {req_a[DATA_W-2:0], 1'b0}; alu_res.cc[1] = req_a[DATA_W-1]; end
      4'd7: begin alu_res.e = {1'b0, req_a[DATA_W-1:1]}; alu_res.cc[1] = req_a[0]; end
      default: alu_res.e = req_a;
    endcase
    alu_res.cc[0] = (alu_res.e == '0);
  end

  // One partial product per MUL cycle; the result is taken from the final sum.
  always_comb begin
    acc_nxt = acc;
    if (b_q[cnt]) acc_nxt = acc + ({{DATA_W{1'b0}}, a_q} << cnt);
    mul_res.e  = acc_nxt[DATA_W-1:0];
    mul_res.cc = {|acc_nxt[2*DATA_W-1:DATA_W], (acc_nxt[DATA_W-1:0] == '0)};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      acc    <= '0;
      rsp_e  <= '0;
      rsp_cc <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q <= req_a;
          b_q <= req_b;
          cnt <= '0;
          acc <= '0;
          if (req_op != OP_MUL) {rsp_e, rsp_cc} <= alu_res;
        end
        MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (mul_last) {rsp_e, rsp_cc} <= mul_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: driver pushes expected {E,cc} on accept,
// a negedge monitor pops on each response handshake and checks hold stability.
module tb_alu_exec_unit;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req_valid = 1'b0, rsp_ready = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic [3:0]   req_op = '0;
  logic         req_ready, rsp_valid, busy;
  logic [W-1:0] rsp_e;
  logic [1:0]   rsp_cc;

  int         checks = 0, errors = 0;
  logic [9:0] exp_q[$];
  bit         rand_rdy = 1'b0;
  bit         held = 1'b0;
  logic [9:0] held_v;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(W), .MUL_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_e(rsp_e), .rsp_cc(rsp_cc), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on handshake, verifies E/cc unchanged across stall cycles.
  always @(negedge clk) begin
    if (!rst_n) held = 1'b0;
    else begin
      if (rsp_valid && held) check("rsp hold", {rsp_e, rsp_cc}, held_v);
      if (rsp_valid && rsp_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) check("spurious rsp", exp_q.size(), 1);
        else check("rsp E/cc", {rsp_e, rsp_cc}, exp_q.pop_front());
      end else if (rsp_valid) begin
        held   = 1'b1;
        held_v = {rsp_e, rsp_cc};
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic [7:0] ee, input logic [1:0] ec);
    int n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("req_ready timeout", req_ready, 1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    @(posedge clk);
    exp_q.push_back({ee, ec});
    #1 req_valid = 1'b0;
  endtask

  // Edges after the accept edge until rsp_valid is seen (0 = next cycle).
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!rsp_valid && edges < 50) begin @(posedge clk); #1; edges++; end
  endtask

  function automatic logic [9:0] model(input int a, input int b, input int op);
    int e = 0;
    bit c = 1'b0;
    case (op)
      0: begin e = a + b; c = (e > 255); end
      1: begin e = a - b; c = (a < b); end
      2: e = a & b;
      default: e = a | b;
    endcase
    e = e & 255;
    return {e[7:0], c, (e == 0)};
  endfunction

  typedef struct { logic [7:0] a, b; logic [3:0] op; logic [7:0] e; logic [1:0] cc; } vec_t;
  vec_t vecs[$] = '{
    '{8'd255, 8'd0,   4'd6,  8'd254,  2'b10},
    '{8'd77,  8'd0,   4'd8,  8'd0,    2'b01},
    '{8'd255, 8'd255, 4'd8,  8'h01,   2'b10},
    '{8'h81,  8'd0,   4'd7,  8'h40,   2'b10},
    '{8'hF0,  8'h0F,  4'd4,  8'hFF,   2'b00},
    '{8'hAA,  8'd0,   4'd5,  8'h55,   2'b00},
    '{8'h0F,  8'hF0,  4'd2,  8'h00,   2'b01},
    '{8'h0F,  8'h30,  4'd3,  8'h3F,   2'b00},
    '{8'h5A,  8'h11,  4'd12, 8'h5A,   2'b00},
    '{8'd0,   8'd9,   4'd15, 8'd0,    2'b01}
  };

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [9:0] m;
    #12;
    check("reset rsp_valid", rsp_valid, 0);
    check("reset busy", busy, 0);
    check("reset E/cc", {rsp_e, rsp_cc}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1 check("ready after reset", req_ready, 1);

    // 1: basic ADD, latency and ready recovery
    rsp_ready = 1'b1;
    send(8'd3, 8'd2, 4'd0, 8'd5, 2'b00);
    wait_valid(e);
    check("t1 latency", e, 0);
    @(posedge clk); #1;
    check("t1 req_ready", req_ready, 1);
    check("t1 rsp_valid drop", rsp_valid, 0);

    // 2: ADD wrap and SUB borrow
    send(8'd255, 8'd1, 4'd0, 8'd0, 2'b11);
    wait_valid(e);
    send(8'd2, 8'd3, 4'd1, 8'd255, 2'b10);
    wait_valid(e);

    // 3: MUL latency and stall hold
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(8'd16, 8'd17, 4'd8, 8'h10, 2'b10);
    check("t3 busy", busy, 1);
    check("t3 ready low", req_ready, 0);
    wait_valid(e);
    check("t3 latency", e, 8);
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // directed boundary / op table
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e, vecs[i].cc);
      wait_valid(e);
    end

    // 4: reset during MUL discards the op
    send(8'd16, 8'd17, 4'd8, 8'h10, 2'b10);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t4 rsp_valid", rsp_valid, 0);
    check("t4 busy", busy, 0);
    check("t4 E/cc", {rsp_e, rsp_cc}, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'd3, 8'd2, 4'd0, 8'd5, 2'b00);
    wait_valid(e);
    check("t4 latency", e, 0);

    // 5: requests while busy are ignored
    @(posedge clk); #1 rsp_ready = 1'b0;
    send(8'd5, 8'd6, 4'd8, 8'd30, 2'b00);
    wait_valid(e);
    req_valid = 1'b1; req_a = 8'd9; req_b = 8'd9; req_op = 4'd0;
    repeat (3) begin
      @(posedge clk); #1;
      check("t5 ready low", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("t5 no 2nd rsp", rsp_valid, 0);

    // 6: sweep with random backpressure
    rand_rdy = 1'b1;
    for (int b = 2; b <= 41; b++) begin
      m = model(3, b, (b - 2) % 4);
      send(8'd3, 8'(b), 4'((b - 2) % 4), m[9:2], m[1:0]);
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("drain queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
